uart_gram_writer: RTL and testbench



---
 rtl/gc_pkg.sv | 32 +++
 rtl/uart_rx_core.sv | 125 ++++++++++++
 rtl/uart_gram_writer.sv | 163 ++++++++++++++++
 tb/tb_uart_gram_writer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// gc_pkg: command codes, FSM encodings and GRAM widths shared by the UART GRAM writer (UART_PARITY_EN adds RX_PARITY)
package gc_pkg;
  localparam int GRAM_AW = 12;
  localparam int GRAM_DW = 7;
  localparam logic [7:0] CMD_SET_CURSOR = 8'hFF;
  localparam logic [7:0] CMD_CLEAR_CODE = 8'hFE;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;
  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_ROW,
    CMD_COL,
    CMD_CLEAR
  } cmd_state_e;
  // row*cols as a shift-and-add over the row bits, so no multiplier is built
  function automatic logic [GRAM_AW-1:0] row_times_cols(input logic [7:0] row, input logic [GRAM_AW-1:0] cols);
    logic [GRAM_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = row[i] ? acc + (cols << i) : acc;
    return acc;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: rxd synchroniser, 16x oversample tick and RX FSM; 8N1, or 8E1 when UART_PARITY_EN is defined
module uart_rx_core
  import gc_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error,
  output logic       clk_uart_enable
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  os_q, os_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        tick_q, tick_d;
  logic        rx, tick, mid, par_ok;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
  assign par_ok = ~^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif
  assign rx              = sync_q[1];
  assign tick            = div_q == DIV_LAST;
  assign mid             = tick && os_q == 4'd15;
  assign byte_valid      = valid_q;
  assign byte_data       = data_q;
  assign frame_error     = ferr_q;
  assign clk_uart_enable = tick_q;
  // state and datapath registers; synchroniser idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      tick_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      tick_q  <= tick_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  // frame decode: start qualified at tick 8, then every 16 ticks samples mid-bit
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], rxd};
    div_d   = tick ? '0 : div_q + 16'd1;
    os_d    = tick ? os_q + 4'd1 : os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    tick_d  = tick;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      RX_IDLE: if (!rx) begin
        state_d = RX_START;
        div_d   = '0;
        os_d    = '0;
      end
      RX_START: if (tick && os_q == 4'd7) begin
        state_d = rx ? RX_IDLE : RX_DATA;
        os_d    = '0;
        bit_d   = '0;
      end
      RX_DATA: if (mid) begin
        shift_d = {rx, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_PARITY_EN
        if (bit_q == 3'd7) state_d = RX_PARITY;
      end
      RX_PARITY: if (mid) begin
        par_d   = rx;
        state_d = RX_STOP;
      end
`else
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
`endif
      RX_STOP: if (mid) begin
        valid_d = rx && par_ok;
        ferr_d  = !(rx && par_ok);
        data_d  = shift_q;
        state_d = rx ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_gram_writer.sv
// uart_gram_writer: turns a UART command stream into GRAM writes at an auto-advancing cursor (UART_PARITY_EN selects 8E1)
module uart_gram_writer
  import gc_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int COLS     = 80,
  parameter int ROWS     = 30,
  parameter logic [GRAM_DW-1:0] CLEAR_CHAR = 7'h20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  output logic               clk_uart_enable,
  output logic [GRAM_DW-1:0] gram_write_data,
  output logic [GRAM_AW-1:0] gram_write_address,
  output logic               gram_write_enable,
  output logic               busy,
  output logic               frame_error,
  output logic               overrun
);
  localparam logic [7:0] COLS_B = 8'(COLS);
  localparam logic [7:0] ROWS_B = 8'(ROWS);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [GRAM_AW-1:0] COLS_A = GRAM_AW'(COLS);
  localparam logic [GRAM_AW-1:0] LAST_ADDR = GRAM_AW'(COLS * ROWS - 1);
  cmd_state_e         state_q, state_d;
  logic [7:0]         row_q, row_d, col_q, col_d, set_row_q, set_row_d;
  logic [GRAM_AW-1:0] base_q, base_d, clr_q, clr_d, waddr_q, waddr_d;
  logic [GRAM_DW-1:0] wdata_q, wdata_d;
  logic [7:0]         pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               we_q, we_d, busy_q, busy_d, ovr_q, ovr_d;
  logic               rx_valid, from_pend, in_valid, col_last, row_wrap;
  logic [7:0]         rx_data, in_data, next_row;
  logic [GRAM_AW-1:0] next_base;
  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk             (clk),
    .rst_n           (rst_n),
    .rxd             (rxd),
    .byte_valid      (rx_valid),
    .byte_data       (rx_data),
    .frame_error     (frame_error),
    .clk_uart_enable (clk_uart_enable)
  );
  assign from_pend          = pend_v_q && state_q != CMD_CLEAR;
  assign in_valid           = from_pend || (rx_valid && state_q != CMD_CLEAR);
  assign in_data            = from_pend ? pend_q : rx_data;
  assign col_last           = col_q == LAST_COL;
  assign row_wrap           = row_q == LAST_ROW;
  assign next_row           = row_wrap ? '0 : row_q + 8'd1;
  assign next_base          = row_wrap ? '0 : base_q + COLS_A;
  assign gram_write_enable  = we_q;
  assign gram_write_data    = wdata_q;
  assign gram_write_address = waddr_q;
  assign busy               = busy_q;
  assign overrun            = ovr_q;
  // command FSM, cursor, pending byte and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CMD_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      set_row_q <= '0;
      base_q    <= '0;
      clr_q     <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      set_row_q <= set_row_d;
      base_q    <= base_d;
      clr_q     <= clr_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end
  // byte decode; during a clear, arriving bytes park in the one-entry pending slot
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    set_row_d = set_row_q;
    base_d    = base_q;
    clr_d     = clr_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    busy_d    = 1'b0;
    ovr_d     = 1'b0;
    if (state_q == CMD_CLEAR) begin
      if (rx_valid) begin
        ovr_d    = pend_v_q;
        pend_v_d = 1'b1;
        pend_d   = pend_v_q ? pend_q : rx_data;
      end
    end else if (from_pend) begin
      pend_v_d = rx_valid;
      pend_d   = rx_data;
    end
    case (state_q)
      CMD_IDLE: if (in_valid) begin
        if (in_data == CMD_SET_CURSOR) state_d = CMD_ROW;
        else if (in_data == CMD_CLEAR_CODE) begin
          state_d = CMD_CLEAR;
          clr_d   = '0;
        end else if (in_data == LF || in_data == CR) begin
          col_d  = '0;
          row_d  = in_data == LF ? next_row : row_q;
          base_d = in_data == LF ? next_base : base_q;
        end else if (!in_data[7]) begin
          we_d    = 1'b1;
          wdata_d = in_data[6:0];
          waddr_d = base_q + GRAM_AW'(col_q);
          col_d   = col_last ? '0 : col_q + 8'd1;
          row_d   = col_last ? next_row : row_q;
          base_d  = col_last ? next_base : base_q;
        end
      end
      CMD_ROW: if (in_valid) begin
        set_row_d = in_data;
        state_d   = CMD_COL;
      end
      CMD_COL: if (in_valid) begin
        state_d = CMD_IDLE;
        if (set_row_q < ROWS_B && in_data < COLS_B) begin
          row_d  = set_row_q;
          col_d  = in_data;
          base_d = row_times_cols(set_row_q, COLS_A);
        end
      end
      CMD_CLEAR: begin
        we_d    = 1'b1;
        busy_d  = 1'b1;
        wdata_d = CLEAR_CHAR;
        waddr_d = clr_q;
        clr_d   = clr_q + 1'b1;
        if (clr_q == LAST_ADDR) begin
          state_d = CMD_IDLE;
          row_d   = '0;
          col_d   = '0;
          base_d  = '0;
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_gram_writer.sv
// tb_uart_gram_writer: directed serial stimulus with a write scoreboard checked by an independent monitor
module tb_uart_gram_writer;
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD = 781250;
  localparam int BIT_CLKS = 16 * (CLK_FREQ / (BAUD * 16));
  localparam int CELLS = 80 * 30;
  typedef struct {
    logic [11:0] a;
    logic [6:0]  d;
  } wr_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        clk_uart_enable, gram_write_enable, busy, frame_error, overrun;
  logic [6:0]  gram_write_data;
  logic [11:0] gram_write_address;
  wr_t         exp_q[$];
  int          busy_exp_q[$];
  wr_t         mon_e;
  int          checks = 0, errors = 0;
  int          fe_cnt = 0, ov_cnt = 0, wr_cnt = 0, busy_run = 0, busy_want = 0;
  uart_gram_writer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rxd                (rxd),
    .clk_uart_enable    (clk_uart_enable),
    .gram_write_data    (gram_write_data),
    .gram_write_address (gram_write_address),
    .gram_write_enable  (gram_write_enable),
    .busy               (busy),
    .frame_error        (frame_error),
    .overrun            (overrun)
  );
  always #10 clk = ~clk;
  // monitor: pops expected writes and busy-run lengths, counts event pulses
  always @(negedge clk) begin
    if (rst_n && gram_write_enable) begin
      checks++;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: addr %0d data %h, none expected", gram_write_address, gram_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (gram_write_address != mon_e.a || gram_write_data != mon_e.d) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                   gram_write_address, gram_write_data, mon_e.a, mon_e.d);
        end
      end
    end
    if (!rst_n) busy_run = 0;
    else if (busy) busy_run++;
    else if (busy_run != 0) begin
      checks++;
      if (busy_exp_q.size() == 0) begin
        errors++;
        $display("FAIL busy_unexpected: busy high %0d clks, none expected", busy_run);
      end else begin
        busy_want = busy_exp_q.pop_front();
        if (busy_run != busy_want) begin
          errors++;
          $display("FAIL busy_len: got %0d expected %0d", busy_run, busy_want);
        end
      end
      busy_run = 0;
    end
    if (rst_n && frame_error) fe_cnt++;
    if (rst_n && overrun) ov_cnt++;
  end
  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask
  task automatic push(input int a, input int d);
    wr_t w;
    w.a = 12'(a);
    w.d = 7'(d);
    exp_q.push_back(w);
  endtask
  task automatic push_clear();
    for (int i = 0; i < CELLS; i++) push(i, 'h20);
    busy_exp_q.push_back(CELLS);
  endtask
  task automatic tx_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(posedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
`ifdef UART_PARITY_EN
    tx_bit(^b);
`endif
    tx_bit(stop);
    if (!stop) begin
      tx_bit(1'b1);
      tx_bit(1'b1);
    end
  endtask
  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_exp_q.size() != 0 || busy) && n < 6000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
    busy_exp_q.delete();
  endtask
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", gram_write_enable, 0);
    chk("rst_addr", gram_write_address, 0);
    chk("rst_data", gram_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    push(0, 'h41); send(8'h41, 1'b1);
    push(1, 'h42); send(8'h42, 1'b1);
    drain("ab");
    send(8'hFF, 1'b1); send(8'h02, 1'b1); send(8'h05, 1'b1);
    push(165, 'h58); send(8'h58, 1'b1);
    send(8'hFF, 1'b1); send(8'h1E, 1'b1); send(8'h00, 1'b1);
    push(166, 'h61); send(8'h61, 1'b1);
    drain("cursor");
    send(8'hFF, 1'b1); send(8'h1D, 1'b1); send(8'h4F, 1'b1);
    push(2399, 'h5A); send(8'h5A, 1'b1);
    push(0, 'h59); send(8'h59, 1'b1);
    send(8'hFF, 1'b1); send(8'h1D, 1'b1); send(8'h0A, 1'b1);
    send(8'h0A, 1'b1);
    push(0, 'h31); send(8'h31, 1'b1);
    send(8'h0D, 1'b1);
    push(0, 'h32); send(8'h32, 1'b1);
    send(8'h90, 1'b1);
    push(1, 'h33); send(8'h33, 1'b1);
    drain("wrap");
    push_clear();
    send(8'hFE, 1'b1);
    drain("clear");
    push(0, 'h4B); send(8'h4B, 1'b1);
    drain("after_clear");
    send(8'h55, 1'b0);
    drain("frame");
    chk("frame_error_pulses", fe_cnt, 1);
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    rxd = 1'b1;
    repeat (200) @(posedge clk);
    chk("glitch_no_error", fe_cnt, 1);
    push(1, 'h47); send(8'h47, 1'b1);
    drain("after_glitch");
    chk("no_overrun_yet", ov_cnt, 0);
    push_clear();
    push(0, 'h50);
    send(8'hFE, 1'b1); send(8'h50, 1'b1); send(8'h51, 1'b1);
    drain("overrun");
    chk("overrun_pulses", ov_cnt, 1);
    push_clear();
    send(8'hFE, 1'b1);
    n = wr_cnt;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    busy_exp_q.delete();
    @(negedge clk);
    chk("clear_started", (wr_cnt > n) ? 1 : 0, 1);
    chk("abort_busy", busy, 0);
    chk("abort_we", gram_write_enable, 0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (3000) @(posedge clk);
    push(0, 'h52); send(8'h52, 1'b1);
    drain("after_abort");
    chk("final_ferr", fe_cnt, 1);
    chk("final_ovr", ov_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
